if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the PC, address and immediate width.
REQ-002 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-003 clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 ifu_req_valid_o  out  1  SHALL flag a fetch request to instruction memory.
REQ-006 ifu_req_ready_i  in  1  SHALL flag that memory accepts the request.
REQ-007 ifu_req_addr_o  out  XLEN  SHALL carry the fetch PC.
REQ-008 ifu_rsp_valid_i  in  1  SHALL flag that the instruction is returned.
REQ-009 ifu_rsp_instr_i  in  32  SHALL carry the returned instruction.
REQ-010 md_instr_o  out  32  SHALL carry the buffered instruction to the mini-decoder.
REQ-011 md_jal_i, md_jalr_i, md_branch_i  in  1 each  SHALL carry the mini-decoder class flags.
REQ-012 md_imm_i  in  XLEN  SHALL carry the mini-decoder sign-extended immediate.
REQ-013 if_valid_o  out  1  SHALL flag an instruction offered to ID.
REQ-014 id_ready_i  in  1  SHALL flag that ID accepts it.
REQ-015 if_instr_o  out  32, if_pc_o  out  XLEN, if_pred_taken_o  out  1  SHALL carry the instruction, its PC and the prediction.
REQ-016 ex_redirect_i  in  1, ex_redirect_pc_i  in  XLEN  SHALL carry a flush/redirect from EX.

Function
REQ-017 The block SHALL have the FSM states IDLE, REQ, WAIT, OUT, JSTALL and DRAIN, with one request outstanding at most.
REQ-018 IDLE SHALL move to REQ unconditionally on the next clock edge.
REQ-019 In REQ, ifu_req_valid_o SHALL be 1 and ifu_req_addr_o SHALL be pc; the FSM SHALL move to WAIT when ifu_req_ready_i is 1.
REQ-020 In WAIT, on ifu_rsp_valid_i the block SHALL latch ifu_rsp_instr_i into the instruction buffer and move to OUT.
REQ-021 In OUT, if_valid_o SHALL be 1, and if_instr_o and md_instr_o SHALL both be the buffer, with if_pc_o equal to pc.
REQ-022 Prediction SHALL be combinational from the md_* inputs: jal is taken, target pc+md_imm_i; a branch with md_imm_i[XLEN-1]=1 (backward) is taken, target pc+md_imm_i; everything else is not taken, next pc+4; all sums are modulo 2^XLEN.
REQ-023 if_pred_taken_o SHALL be 1 exactly when the OUT-state prediction is taken, and 0 otherwise.
REQ-024 On an OUT handshake (if_valid_o and id_ready_i), pc SHALL load the predicted next PC and the FSM SHALL move to REQ, except for jalr.
REQ-025 For a jalr handshake, pc SHALL hold and the FSM SHALL move to JSTALL, where no request is issued until ex_redirect_i.
REQ-026 While id_ready_i is 0 in OUT, all of if_instr_o, if_pc_o and if_pred_taken_o SHALL remain stable.
REQ-027 ex_redirect_i SHALL have priority over every other event in every state, and pc SHALL load {ex_redirect_pc_i[XLEN-1:2], 2'b00}.
REQ-028 A redirect in REQ without ready, or in IDLE, OUT or JSTALL, SHALL move the FSM to REQ.
REQ-029 A redirect in WAIT without a response, or in REQ with the request accepted that cycle, SHALL move the FSM to DRAIN.
REQ-030 In DRAIN, the next ifu_rsp_valid_i SHALL be discarded and the FSM SHALL move to REQ.
REQ-031 A redirect in WAIT with ifu_rsp_valid_i in the same cycle SHALL discard the response and move the FSM to REQ.
REQ-032 A redirect in OUT with id_ready_i in the same cycle SHALL void the handshake: no prediction update, and the FSM goes to REQ.
REQ-033 ifu_req_valid_o SHALL be 0 and if_valid_o SHALL be 0 in every state other than REQ and OUT respectively.

Reset
REQ-034 While rst_i is 1, the FSM SHALL be IDLE and pc SHALL be RESET_PC.
REQ-035 While rst_i is 1, the instruction buffer SHALL be 32'h0000_0013 (nop), and ifu_req_valid_o, if_valid_o and if_pred_taken_o SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL abandon any outstanding request.
REQ-037 After a reset, any response to a request from before that reset SHALL NOT be forwarded.

Verification
REQ-038 Release reset, ready=1, rsp the next cycle with addi -> first request addr 0x8000_0000, OUT pc 0x8000_0000, pred_taken 0, next request 0x8000_0004.
REQ-039 At pc 0x8000_0010, jal with imm 0x100 -> pred_taken 1, next request 0x8000_0110; then beq with imm -8 at 0x8000_0110 -> next request 0x8000_0108.
REQ-040 Forward beq, imm +16, at 0x8000_0000 -> pred_taken 0, next request 0x8000_0004.
REQ-041 jalr accepted by ID -> no request for 10 cycles; ex_redirect_pc 0x8000_0203 -> next request 0x8000_0200.
REQ-042 Redirect to 0x8000_0400 while WAIT, late rsp 3 cycles later -> that rsp dropped, if_valid_o stays 0, next request 0x8000_0400.
REQ-043 Hold id_ready_i=0 for 5 cycles in OUT, then assert rst_i -> outputs stable over the 5 cycles, then all outputs 0 immediately, first request after release 0x8000_0000.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: single outstanding fetch, one-entry instruction buffer,
// static jal/backward-branch prediction, jalr stall and EX redirect with response draining.
module if_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            ifu_req_valid_o,
  input  logic            ifu_req_ready_i,
  output logic [XLEN-1:0] ifu_req_addr_o,
  input  logic            ifu_rsp_valid_i,
  input  logic [31:0]     ifu_rsp_instr_i,
  output logic [31:0]     md_instr_o,
  input  logic            md_jal_i,
  input  logic            md_jalr_i,
  input  logic            md_branch_i,
  input  logic [XLEN-1:0] md_imm_i,
  output logic            if_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            if_pred_taken_o,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_redirect_pc_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_JSTALL,
    S_DRAIN
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     buf_q, buf_d;
  logic            req_valid_q;
  logic            out_valid_q;
  logic            pred_taken;
  logic [XLEN-1:0] pred_pc;
  logic [XLEN-1:0] redir_pc;

  always_comb begin
    pred_taken = md_jal_i | (md_branch_i & md_imm_i[XLEN-1]);
    pred_pc    = pc_q + (pred_taken ? md_imm_i : XLEN'(4));
    redir_pc   = {ex_redirect_pc_i[XLEN-1:2], 2'b00};
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    if (ex_redirect_i) begin
      pc_d = redir_pc;
      // A request already accepted (or still in flight) must have its response drained.
      case (state_q)
        S_REQ:           state_d = ifu_req_ready_i ? S_DRAIN : S_REQ;
        S_WAIT, S_DRAIN: state_d = ifu_rsp_valid_i ? S_REQ : S_DRAIN;
        default:         state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  if (ifu_req_ready_i) state_d = S_WAIT;
        S_WAIT: begin
          if (ifu_rsp_valid_i) begin
            buf_d   = ifu_rsp_instr_i;
            state_d = S_OUT;
          end
        end
        S_OUT: begin
          if (id_ready_i) begin
            if (md_jalr_i) begin
              state_d = S_JSTALL;
            end else begin
              pc_d    = pred_pc;
              state_d = S_REQ;
            end
          end
        end
        S_JSTALL: state_d = S_JSTALL;
        S_DRAIN:  if (ifu_rsp_valid_i) state_d = S_REQ;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      buf_q       <= NOP;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      req_valid_q <= (state_d == S_REQ);
      out_valid_q <= (state_d == S_OUT);
    end
  end

  assign ifu_req_valid_o = req_valid_q;
  assign ifu_req_addr_o  = req_valid_q ? pc_q : '0;
  assign md_instr_o      = buf_q;
  assign if_valid_o      = out_valid_q;
  assign if_instr_o      = out_valid_q ? buf_q : '0;
  assign if_pc_o         = out_valid_q ? pc_q : '0;
  assign if_pred_taken_o = out_valid_q & pred_taken;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus randomized traffic, all checked each cycle
// against a transaction-level model of the fetch stream.
module tb_if_fetch_ctrl;
  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADDI    = 32'h0010_0093;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;
  localparam logic [6:0]  OP_JALR = 7'b1100111;
  localparam logic [6:0]  OP_BR   = 7'b1100011;
  localparam logic [6:0]  OP_ALU  = 7'b0010011;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ifu_req_valid_o, ifu_req_ready_i;
  logic [31:0] ifu_req_addr_o;
  logic        ifu_rsp_valid_i;
  logic [31:0] ifu_rsp_instr_i;
  logic [31:0] md_instr_o;
  logic        md_jal_i, md_jalr_i, md_branch_i;
  logic [31:0] md_imm_i;
  logic        if_valid_o, id_ready_i;
  logic [31:0] if_instr_o, if_pc_o;
  logic        if_pred_taken_o;
  logic        ex_redirect_i;
  logic [31:0] ex_redirect_pc_i;

  if_fetch_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_req_valid_o(ifu_req_valid_o), .ifu_req_ready_i(ifu_req_ready_i),
    .ifu_req_addr_o(ifu_req_addr_o),
    .ifu_rsp_valid_i(ifu_rsp_valid_i), .ifu_rsp_instr_i(ifu_rsp_instr_i),
    .md_instr_o(md_instr_o),
    .md_jal_i(md_jal_i), .md_jalr_i(md_jalr_i), .md_branch_i(md_branch_i), .md_imm_i(md_imm_i),
    .if_valid_o(if_valid_o), .id_ready_i(id_ready_i),
    .if_instr_o(if_instr_o), .if_pc_o(if_pc_o), .if_pred_taken_o(if_pred_taken_o),
    .ex_redirect_i(ex_redirect_i), .ex_redirect_pc_i(ex_redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in mini-decoder: real RV opcodes, immediate = sign-extended instr[31:12] << 1.
  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31:12], 1'b0};
  endfunction
  function automatic logic [31:0] mk(input logic [6:0] op, input logic [31:0] imm);
    logic [31:0] t;
    t = imm;
    return {t[20:1], 5'd0, op};
  endfunction
  function automatic logic taken_of(input logic [31:0] ins);
    logic [31:0] im;
    im = imm_of(ins);
    return (ins[6:0] == OP_JAL) || ((ins[6:0] == OP_BR) && im[31]);
  endfunction

  assign md_jal_i    = (md_instr_o[6:0] == OP_JAL);
  assign md_jalr_i   = (md_instr_o[6:0] == OP_JALR);
  assign md_branch_i = (md_instr_o[6:0] == OP_BR);
  assign md_imm_i    = imm_of(md_instr_o);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  bit          rand_mode = 0;
  int          fixed_lat = 0;
  bit          inject_stray = 0;
  logic [31:0] prog [logic [31:0]];
  logic [31:0] req_log [$];
  logic [31:0] hs_pc [$];
  bit          hs_pred [$];

  function automatic logic [31:0] gen(input logic [31:0] a);
    int r;
    if (!rand_mode) return prog.exists(a) ? prog[a] : ADDI;
    r = $urandom_range(0, 7);
    case (r)
      3:       return mk(OP_JAL, $urandom);
      4:       return mk(OP_JALR, $urandom);
      5, 6:    return mk(OP_BR, $urandom);
      7:       return $urandom;
      default: return mk(OP_ALU, $urandom);
    endcase
  endfunction

  // Instruction memory: one request at a time, response after a programmable latency.
  initial begin
    bit busy, acc, rst_now;
    int lat;
    logic [31:0] addr, acc_addr;
    busy = 0; lat = 0; addr = '0;
    ifu_req_ready_i = 1'b1; ifu_rsp_valid_i = 1'b0; ifu_rsp_instr_i = '0;
    forever begin
      @(negedge clk_i);
      rst_now  = rst_i;
      acc      = ifu_req_valid_o && ifu_req_ready_i && !rst_i;
      acc_addr = ifu_req_addr_o;
      if (acc) req_log.push_back(acc_addr);
      @(posedge clk_i); #1;
      ifu_rsp_valid_i = 1'b0;
      if (rst_now) busy = 0;
      if (acc) begin
        busy = 1;
        lat  = rand_mode ? $urandom_range(0, 3) : fixed_lat;
        addr = acc_addr;
      end
      ifu_req_ready_i = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (busy) begin
        if (lat == 0) begin
          ifu_rsp_valid_i = 1'b1;
          ifu_rsp_instr_i = gen(addr);
          busy = 0;
        end else lat--;
      end else if (inject_stray) begin
        ifu_rsp_valid_i = 1'b1;
        ifu_rsp_instr_i = 32'hDEAD_BEEF;
        inject_stray = 0;
      end
    end
  end

  // Reference model of the fetch stream and the per-cycle compare.
  initial begin
    bit idle, outst, squash, have, jstall, exp_req, tk;
    logic [31:0] exp_pc, bufi;
    idle = 1; outst = 0; squash = 0; have = 0; jstall = 0; exp_pc = RST_PC; bufi = NOP;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        chk1("rst_req_valid", ifu_req_valid_o, 1'b0);
        chk1("rst_if_valid", if_valid_o, 1'b0);
        chk1("rst_pred", if_pred_taken_o, 1'b0);
        chk("rst_md_instr", md_instr_o, NOP);
        idle = 1; outst = 0; squash = 0; have = 0; jstall = 0; exp_pc = RST_PC; bufi = NOP;
      end else begin
        exp_req = !idle && !outst && !have && !jstall;
        tk = taken_of(bufi);
        chk1("req_valid", ifu_req_valid_o, exp_req);
        if (exp_req) chk("req_addr", ifu_req_addr_o, exp_pc);
        chk1("if_valid", if_valid_o, have);
        if (have) begin
          chk("if_instr", if_instr_o, bufi);
          chk("md_instr", md_instr_o, bufi);
          chk("if_pc", if_pc_o, exp_pc);
          chk1("if_pred", if_pred_taken_o, tk);
        end else chk1("pred_no_out", if_pred_taken_o, 1'b0);
        idle = 0;
        if (ex_redirect_i) begin
          if (exp_req && ifu_req_ready_i) begin outst = 1; squash = 1; end
          else if (outst && ifu_rsp_valid_i) begin outst = 0; squash = 0; end
          else if (outst) squash = 1;
          have = 0; jstall = 0;
          exp_pc = {ex_redirect_pc_i[31:2], 2'b00};
        end else if (exp_req && ifu_req_ready_i) begin
          outst = 1; squash = 0;
        end else if (outst && ifu_rsp_valid_i) begin
          outst = 0;
          if (!squash) begin have = 1; bufi = ifu_rsp_instr_i; end
          squash = 0;
        end else if (have && id_ready_i) begin
          hs_pc.push_back(exp_pc);
          hs_pred.push_back(tk);
          have = 0;
          if (bufi[6:0] == OP_JALR) jstall = 1;
          else exp_pc = tk ? exp_pc + imm_of(bufi) : exp_pc + 32'd4;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask
  task automatic reset_dut();
    cyc();
    rst_i = 1'b1;
    repeat (2) cyc();
    req_log.delete(); hs_pc.delete(); hs_pred.delete();
    rst_i = 1'b0;
  endtask
  task automatic wait_req(input int n);
    int k = 0;
    while (req_log.size() < n && k < 200) begin cyc(); k++; end
    if (req_log.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_req: got %0d requests expected %0d", req_log.size(), n);
    end
  endtask
  task automatic wait_hs(input int n);
    int k = 0;
    while (hs_pc.size() < n && k < 200) begin cyc(); k++; end
    if (hs_pc.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_hs: got %0d handshakes expected %0d", hs_pc.size(), n);
    end
  endtask
  task automatic chk_log(input string name, input int i, input logic [31:0] exp);
    if (i < req_log.size()) chk(name, req_log[i], exp);
    else begin n_cmp++; n_bad++; $display("FAIL %s: got no request expected %h", name, exp); end
  endtask
  task automatic chk_hs(input string name, input int i, input logic [31:0] pc, input bit pred);
    if (i < hs_pc.size()) begin
      chk({name, "_pc"}, hs_pc[i], pc);
      chk1({name, "_pred"}, hs_pred[i], pred);
    end else begin n_cmp++; n_bad++; $display("FAIL %s: got no handshake expected pc %h", name, pc); end
  endtask

  initial begin
    int k;
    rst_i = 1'b1; id_ready_i = 1'b1; ex_redirect_i = 1'b0; ex_redirect_pc_i = '0;

    // Sequential fetch after reset
    prog.delete();
    reset_dut();
    wait_req(2);
    chk_log("t038_first_req", 0, RST_PC);
    chk_log("t038_next_req", 1, RST_PC + 32'd4);
    chk_hs("t038_out", 0, RST_PC, 1'b0);

    // jal then backward beq
    prog.delete();
    prog[RST_PC + 32'h10]  = mk(OP_JAL, 32'h100);
    prog[RST_PC + 32'h110] = mk(OP_BR, 32'hFFFF_FFF8);
    reset_dut();
    wait_req(7);
    chk_log("t039_jal_pc", 4, RST_PC + 32'h10);
    chk_log("t039_jal_target", 5, RST_PC + 32'h110);
    chk_log("t039_beq_target", 6, RST_PC + 32'h108);
    chk_hs("t039_jal", 4, RST_PC + 32'h10, 1'b1);
    chk_hs("t039_beq", 5, RST_PC + 32'h110, 1'b1);

    // Forward branch not taken
    prog.delete();
    prog[RST_PC] = mk(OP_BR, 32'd16);
    reset_dut();
    wait_req(2);
    chk_log("t040_next_req", 1, RST_PC + 32'd4);
    chk_hs("t040_fwd_beq", 0, RST_PC, 1'b0);

    // jalr stall until redirect
    prog.delete();
    prog[RST_PC] = mk(OP_JALR, 32'd0);
    reset_dut();
    wait_hs(1);
    repeat (10) cyc();
    chk("t041_no_req_in_stall", req_log.size(), 32'd1);
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h8000_0203;
    cyc();
    ex_redirect_i = 1'b0;
    wait_req(2);
    chk_log("t041_redirect_req", 1, 32'h8000_0200);

    // Redirect while waiting, late response dropped
    prog.delete();
    fixed_lat = 3;
    reset_dut();
    wait_req(1);
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h8000_0400;
    cyc();
    ex_redirect_i = 1'b0;
    wait_req(2);
    chk_log("t042_redirect_req", 1, 32'h8000_0400);
    chk("t042_no_forward", hs_pc.size(), 32'd0);
    fixed_lat = 0;

    // Stall in OUT, then asynchronous reset
    prog.delete();
    prog[RST_PC] = mk(OP_JAL, 32'h40);
    id_ready_i = 1'b0;
    reset_dut();
    k = 0;
    while (!if_valid_o && k < 50) begin cyc(); k++; end
    chk1("t043_reach_out", if_valid_o, 1'b1);
    repeat (5) begin
      @(negedge clk_i);
      chk("t043_hold_instr", if_instr_o, mk(OP_JAL, 32'h40));
      chk("t043_hold_pc", if_pc_o, RST_PC);
      chk1("t043_hold_pred", if_pred_taken_o, 1'b1);
    end
    cyc();
    rst_i = 1'b1;
    #1;
    chk1("t043_rst_req_valid", ifu_req_valid_o, 1'b0);
    chk1("t043_rst_if_valid", if_valid_o, 1'b0);
    chk1("t043_rst_pred", if_pred_taken_o, 1'b0);
    chk("t043_rst_if_instr", if_instr_o, 32'd0);
    chk("t043_rst_if_pc", if_pc_o, 32'd0);
    repeat (2) cyc();
    req_log.delete(); hs_pc.delete(); hs_pred.delete();
    rst_i = 1'b0;
    inject_stray = 1;
    id_ready_i = 1'b1;
    wait_req(1);
    chk_log("t043_first_after_rst", 0, RST_PC);
    wait_hs(1);
    chk_hs("t043_after_rst", 0, RST_PC, 1'b1);

    // Randomized traffic
    rand_mode = 1;
    prog.delete();
    reset_dut();
    for (int i = 0; i < 4000; i++) begin
      cyc();
      rst_i            = ($urandom_range(0, 399) == 0);
      id_ready_i       = ($urandom_range(0, 3) != 0);
      ex_redirect_i    = ($urandom_range(0, 24) == 0);
      ex_redirect_pc_i = {16'h8000, 16'($urandom_range(0, 65535))};
    end
    rst_i = 1'b0; ex_redirect_i = 1'b0;
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
